// File: rtl/hart_mem_arbiter_pkg.sv
// Shared types and defaults for the hart memory-port arbiter and its round-robin picker.
package hart_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY   = 2'd1,
    ARB_LOCKED = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_MAX_LOCK = 4;
  localparam int unsigned DEF_LOCK_TMO = 64;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/hart_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping modulo N.
module hart_mem_arbiter_rr_pick
  import hart_mem_arbiter_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned SEL_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     i_req,
  input  logic [SEL_W-1:0] i_last,
  output logic [N-1:0]     o_onehot_c,
  output logic [SEL_W-1:0] o_idx_c,
  output logic             o_any_c
);

  localparam int unsigned IDX_W = clog2_min1(N);

  always_comb begin
    int unsigned cand;
    o_onehot_c = '0;
    o_idx_c    = '0;
    o_any_c    = 1'b0;
    cand       = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(i_last) + i) % N;
      if (!o_any_c && i_req[IDX_W'(cand)]) begin
        o_any_c                  = 1'b1;
        o_onehot_c[IDX_W'(cand)] = 1'b1;
        o_idx_c                  = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/hart_mem_arbiter.sv
// Round-robin arbiter sharing one memory/MMU port among harts, with lock (LR/SC, AMO) hold.
// Optional macro HART_ARB_PERF_EN adds per-hart start counters and a forced-release counter.
module hart_mem_arbiter
  import hart_mem_arbiter_pkg::*;
#(
  parameter int unsigned N_HARTS  = 2,
  parameter int unsigned SEL_W    = $clog2(N_HARTS + 1),
  parameter int unsigned MAX_LOCK = DEF_MAX_LOCK,
  parameter int unsigned LOCK_TMO = DEF_LOCK_TMO
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_HARTS-1:0] i_req,
  input  logic [N_HARTS-1:0] i_lock,
  input  logic               i_mode_is_cpu,
  input  logic               i_mem_done,
  output logic [N_HARTS-1:0] o_grant,
  output logic [SEL_W-1:0]   o_sel,
  output logic               o_mem_start,
  output logic [N_HARTS-1:0] o_hart_busy,
  output logic               o_arb_busy
`ifdef HART_ARB_PERF_EN
  ,
  output logic [32*N_HARTS-1:0] o_grant_cnt,
  output logic [15:0]           o_force_rel_cnt
`endif
);

  localparam int unsigned LCNT_W = clog2_min1(MAX_LOCK);
  localparam int unsigned TCNT_W = clog2_min1(LOCK_TMO);

  arb_state_e          state_q, state_d;
  logic [N_HARTS-1:0]  grant_q, grant_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    r_last_q, r_last_d;
  logic                start_q, start_d;
  logic                arb_busy_q, arb_busy_d;
  logic [LCNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [TCNT_W-1:0]   tmo_cnt_q, tmo_cnt_d;

  logic [N_HARTS-1:0]  pick_onehot;
  logic [SEL_W-1:0]    pick_idx;
  logic                pick_any;

  logic go_c, done_c, own_req_c, own_lock_c, lock_more_c, tmo_hit_c, rel_c;

  hart_mem_arbiter_rr_pick #(
    .N     (N_HARTS),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .i_req      (i_req),
    .i_last     (r_last_q),
    .o_onehot_c (pick_onehot),
    .o_idx_c    (pick_idx),
    .o_any_c    (pick_any)
  );

  // Grant is one-hot, so masking avoids indexing by the wider select.
  assign go_c        = i_mode_is_cpu & pick_any;
  assign done_c      = (state_q == ARB_BUSY) & i_mem_done;
  assign own_req_c   = |(i_req & grant_q);
  assign own_lock_c  = |(i_lock & grant_q);
  assign lock_more_c = own_lock_c & (lock_cnt_q < LCNT_W'(MAX_LOCK - 1));
  assign tmo_hit_c   = (tmo_cnt_q == TCNT_W'(LOCK_TMO - 1));
  assign rel_c       = (state_q == ARB_LOCKED) & ~own_req_c & (~own_lock_c | tmo_hit_c);

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      sel_q      <= '0;
      r_last_q   <= SEL_W'(N_HARTS - 1);
      start_q    <= 1'b0;
      arb_busy_q <= 1'b0;
      lock_cnt_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sel_q      <= sel_d;
      r_last_q   <= r_last_d;
      start_q    <= start_d;
      arb_busy_q <= arb_busy_d;
      lock_cnt_q <= lock_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (go_c) state_d = ARB_BUSY;
      ARB_BUSY:   if (i_mem_done) state_d = lock_more_c ? ARB_LOCKED : ARB_IDLE;
      ARB_LOCKED: begin
        if (own_req_c)  state_d = ARB_BUSY;
        else if (rel_c) state_d = ARB_IDLE;
      end
      default:    state_d = ARB_IDLE;
    endcase
  end

  // Registered outputs, fairness pointer and lock counters.
  always_comb begin
    grant_d    = grant_q;
    sel_d      = sel_q;
    start_d    = 1'b0;
    r_last_d   = r_last_q;
    lock_cnt_d = lock_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    arb_busy_d = (state_d != ARB_IDLE);
    case (state_q)
      ARB_IDLE: begin
        if (go_c) begin
          grant_d = pick_onehot;
          sel_d   = pick_idx;
          start_d = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (i_mem_done) begin
          if (lock_more_c) begin
            lock_cnt_d = lock_cnt_q + LCNT_W'(1);
            tmo_cnt_d  = '0;
          end else begin
            r_last_d   = sel_q;
            grant_d    = '0;
            lock_cnt_d = '0;
          end
        end
      end
      ARB_LOCKED: begin
        if (own_req_c) begin
          start_d = 1'b1;
        end else if (rel_c) begin
          r_last_d   = sel_q;
          grant_d    = '0;
          lock_cnt_d = '0;
          tmo_cnt_d  = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TCNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  assign o_grant     = grant_q;
  assign o_sel       = sel_q;
  assign o_mem_start = start_q;
  assign o_arb_busy  = arb_busy_q;
  // The granted hart is released from stall only in its completion cycle.
  assign o_hart_busy = ~(grant_q & {N_HARTS{done_c}});

`ifdef HART_ARB_PERF_EN
  logic [N_HARTS-1:0][31:0] gcnt_q, gcnt_d;
  logic [15:0]              frc_q, frc_d;
  logic                     force_c;

  assign force_c = (done_c & own_lock_c & ~lock_more_c) |
                   ((state_q == ARB_LOCKED) & ~own_req_c & own_lock_c & tmo_hit_c);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gcnt_q <= '0;
      frc_q  <= '0;
    end else begin
      gcnt_q <= gcnt_d;
      frc_q  <= frc_d;
    end
  end

  // Saturating event counters.
  always_comb begin
    gcnt_d = gcnt_q;
    frc_d  = frc_q;
    for (int unsigned h = 0; h < N_HARTS; h++) begin
      if (start_q && grant_q[h] && (gcnt_q[h] != 32'hFFFF_FFFF)) gcnt_d[h] = gcnt_q[h] + 32'd1;
    end
    if (force_c && (frc_q != 16'hFFFF)) frc_d = frc_q + 16'd1;
  end

  assign o_grant_cnt     = gcnt_q;
  assign o_force_rel_cnt = frc_q;
`endif

endmodule

// File: tb/tb_hart_mem_arbiter.sv
// Self-checking bench for hart_mem_arbiter: transaction-level model plus directed and random stimulus.
module tb_hart_mem_arbiter;

  localparam int N        = 2;
  localparam int MAX_LOCK = 4;
  localparam int LOCK_TMO = 64;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic [N-1:0]            i_req, i_lock;
  logic                    i_mode_is_cpu, i_mem_done;
  logic [N-1:0]            o_grant, o_hart_busy;
  logic [$clog2(N+1)-1:0]  o_sel;
  logic                    o_mem_start, o_arb_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  hart_mem_arbiter #(
    .N_HARTS  (N),
    .MAX_LOCK (MAX_LOCK),
    .LOCK_TMO (LOCK_TMO)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .i_req         (i_req),
    .i_lock        (i_lock),
    .i_mode_is_cpu (i_mode_is_cpu),
    .i_mem_done    (i_mem_done),
    .o_grant       (o_grant),
    .o_sel         (o_sel),
    .o_mem_start   (o_mem_start),
    .o_hart_busy   (o_hart_busy),
    .o_arb_busy    (o_arb_busy)
  );

  // Transaction-level view: who owns the port, whether a transfer is in flight
  // or the lock is being held, and how far the lock sequence / idle wait has got.
  typedef struct {
    int own;
    int last;
    int sel;
    int ntx;
    int idle;
    bit txn;
    bit hold;
    bit st;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t m_reset();
    mstate_t s;
    s.own = -1; s.last = N - 1; s.sel = 0; s.ntx = 0; s.idle = 0;
    s.txn = 1'b0; s.hold = 1'b0; s.st = 1'b0;
    return s;
  endfunction

  function automatic mstate_t model_step(input mstate_t s, input logic [N-1:0] req,
                                         input logic [N-1:0] lock, input logic mode,
                                         input logic done);
    bit rel;
    int h;
    rel  = 1'b0;
    s.st = 1'b0;
    if (s.txn) begin
      if (done) begin
        s.ntx = s.ntx + 1;
        if (lock[s.own] && s.ntx < MAX_LOCK) begin
          s.txn = 1'b0; s.hold = 1'b1; s.idle = 0;
        end else begin
          rel = 1'b1;
        end
      end
    end else if (s.hold) begin
      if (req[s.own]) begin
        s.txn = 1'b1; s.hold = 1'b0; s.st = 1'b1;
      end else if (!lock[s.own] || s.idle + 1 == LOCK_TMO) begin
        rel = 1'b1;
      end else begin
        s.idle = s.idle + 1;
      end
    end else if (mode) begin
      for (int k = 1; k <= N; k++) begin
        h = (s.last + k) % N;
        if (s.own < 0 && req[h]) begin
          s.own = h; s.sel = h; s.txn = 1'b1; s.st = 1'b1; s.ntx = 0;
        end
      end
    end
    if (rel) begin
      s.last = s.own; s.own = -1; s.txn = 1'b0; s.hold = 1'b0; s.ntx = 0; s.idle = 0;
    end
    return s;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) m <= m_reset();
    else     m <= model_step(m, i_req, i_lock, i_mode_is_cpu, i_mem_done);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      logic [31:0] eg, eb;
      eg = (m.own >= 0) ? (32'd1 << m.own) : 32'd0;
      eb = (32'd1 << N) - 32'd1;
      if (m.txn && i_mem_done) eb = eb & ~(32'd1 << m.own);
      check("grant",     32'(o_grant),     eg);
      check("sel",       32'(o_sel),       32'(m.sel));
      check("mem_start", 32'(o_mem_start), 32'(m.st));
      check("arb_busy",  32'(o_arb_busy),  32'(m.txn || m.hold));
      check("hart_busy", 32'(o_hart_busy), eb);
    end
  end

  task automatic wait_start(output int sel, output int n);
    n   = 0;
    sel = -1;
    do begin
      @(negedge CLK);
      n++;
    end while (!o_mem_start && n < 200);
    check("start_seen", 32'(o_mem_start), 32'd1);
    if (o_mem_start) sel = int'(o_sel);
  endtask

  task automatic pulse_done(input int w);
    repeat (w) @(posedge CLK);
    #2 i_mem_done = 1'b1;
    @(posedge CLK);
    #2 i_mem_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, n, cnt;
    int exp_cont[4] = '{1, 0, 1, 0};
    int exp_lock[6] = '{1, 0, 0, 0, 0, 1};

    RST = 1'b0; i_req = '0; i_lock = '0; i_mode_is_cpu = 1'b0; i_mem_done = 1'b0;
    #1 RST = 1'b1;
    #2;
    check("rst_grant",     32'(o_grant),     32'd0);
    check("rst_sel",       32'(o_sel),       32'd0);
    check("rst_start",     32'(o_mem_start), 32'd0);
    check("rst_hart_busy", 32'(o_hart_busy), 32'd3);
    check("rst_arb_busy",  32'(o_arb_busy),  32'd0);
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    tick();

    // Single request.
    i_req = 2'b01; i_mode_is_cpu = 1'b1;
    wait_start(sel, n);
    check("single_latency", 32'(n), 32'd2);
    check("single_grant",   32'(o_grant), 32'd1);
    check("single_sel",     32'(sel), 32'd0);
    pulse_done(3);
    i_req = '0;
    @(negedge CLK);
    check("single_idle", 32'(o_arb_busy), 32'd0);
    tick();

    // Contention: fairness alternates, last winner was hart0.
    i_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_start(sel, n);
      check("contention_order", 32'(sel), 32'(exp_cont[t]));
      pulse_done(2);
    end
    i_req = '0;
    repeat (2) tick();

    // Lock: hart0 keeps the port for MAX_LOCK transfers.
    i_req = 2'b11; i_lock = 2'b01;
    for (int t = 0; t < 6; t++) begin
      wait_start(sel, n);
      check("lock_order", 32'(sel), 32'(exp_lock[t]));
      pulse_done(1);
    end
    i_req = '0; i_lock = '0;
    repeat (2) tick();

    // Lock timeout: hart0 holds the lock but stops requesting.
    i_req = 2'b01; i_lock = 2'b01;
    wait_start(sel, n);
    check("tmo_first", 32'(sel), 32'd0);
    pulse_done(1);
    i_req = 2'b10;
    wait_start(sel, n);
    check("tmo_cycles", 32'(n), 32'd66);
    check("tmo_next",   32'(sel), 32'd1);
    i_lock = '0;
    pulse_done(1);
    i_req = '0;
    repeat (2) tick();

    // Mode gating, and a mode drop inside a lock.
    i_mode_is_cpu = 1'b0; i_req = 2'b11; i_lock = 2'b01;
    cnt = 0;
    repeat (10) begin
      @(negedge CLK);
      if (o_mem_start) cnt++;
    end
    check("gated_starts", 32'(cnt), 32'd0);
    tick();
    i_mode_is_cpu = 1'b1;
    wait_start(sel, n);
    check("ungate_latency", 32'(n), 32'd2);
    check("ungate_sel",     32'(sel), 32'd0);
    pulse_done(1);
    i_mode_is_cpu = 1'b0;
    wait_start(sel, n);
    check("lock_no_mode_latency", 32'(n), 32'd2);
    check("lock_no_mode_sel",     32'(sel), 32'd0);
    i_lock = '0;
    pulse_done(1);
    cnt = 0;
    repeat (5) begin
      @(negedge CLK);
      if (o_mem_start) cnt++;
    end
    check("gated_after_lock", 32'(cnt), 32'd0);
    tick();
    i_req = '0;
    tick();

    // Asynchronous reset in the middle of a transfer.
    i_mode_is_cpu = 1'b1; i_req = 2'b10;
    wait_start(sel, n);
    check("pre_rst_sel", 32'(sel), 32'd1);
    #1 RST = 1'b1;
    #1;
    check("arst_grant",     32'(o_grant),     32'd0);
    check("arst_hart_busy", 32'(o_hart_busy), 32'd3);
    check("arst_arb_busy",  32'(o_arb_busy),  32'd0);
    check("arst_start",     32'(o_mem_start), 32'd0);
    repeat (3) @(posedge CLK);
    #2 RST = 1'b0; i_req = 2'b11;
    wait_start(sel, n);
    check("post_rst_sel", 32'(sel), 32'd0);
    pulse_done(1);
    i_req = '0;
    tick();

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      i_req         = N'($urandom);
      i_lock        = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      i_mode_is_cpu = ($urandom_range(0, 7) != 0);
      i_mem_done    = ($urandom_range(0, 2) == 0);
    end
    tick();
    i_req = '0; i_lock = '0; i_mem_done = 1'b0;
    repeat (LOCK_TMO + 4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
